// File: rtl/alu_chunked_seq_if.sv
// Request/response bundle between the datapath and the chunked sequential ALU.
// The master issues operands with start_i; the slave reports busy/done and the flags.
interface alu_chunked_seq_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [3:0]       ctrl_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             cout_o;
    logic             overflow_o;

    modport master (
        output start_i, ctrl_i, src1_i, src2_i,
        input  busy_o, done_o, result_o, zero_o, cout_o, overflow_o
    );

    modport slave (
        input  start_i, ctrl_i, src1_i, src2_i,
        output busy_o, done_o, result_o, zero_o, cout_o, overflow_o
    );
endinterface

// File: rtl/alu_chunked_seq.sv
// Multi-cycle ALU: CHUNK bits per clock, LSB chunk first, with the ripple carry held
// in a register between chunks. Results and flags load only on the edge entering DONE.
module alu_chunked_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input logic              clk_i,
    input logic              rst_n,
    alu_chunked_seq_if.slave bus
);
    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc_r;
    logic [3:0]       ctrl_r;
    logic [IDX_W-1:0] idx_r;
    logic             carry_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic             cout_r;
    logic             ovf_r;

    logic [CHUNK-1:0] a_chunk_s;
    logic [CHUNK-1:0] b_chunk_s;
    logic [CHUNK:0]   sum_ext_s;
    logic [CHUNK-1:0] chunk_res_s;
    logic [WIDTH-1:0] full_s;
    logic [WIDTH-1:0] final_s;
    logic             ovf_s;
    logic             slt_s;
    logic             valid_op_s;
    logic             arith_s;

    // Slice datapath for the current chunk plus the end-of-operation result selection.
    always_comb begin
        a_chunk_s   = a_r[int'(idx_r)*CHUNK +: CHUNK] ^ {CHUNK{ctrl_r[3]}};
        b_chunk_s   = b_r[int'(idx_r)*CHUNK +: CHUNK] ^ {CHUNK{ctrl_r[2]}};
        sum_ext_s   = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{CHUNK{1'b0}}, carry_r};
        chunk_res_s = '0;
        case (ctrl_r[1:0])
            2'b00:   chunk_res_s = a_chunk_s & b_chunk_s;
            2'b01:   chunk_res_s = a_chunk_s | b_chunk_s;
            default: chunk_res_s = sum_ext_s[CHUNK-1:0];
        endcase

        // Overflow and SLT are only meaningful while the MSB chunk is in the slice.
        ovf_s = (a_chunk_s[CHUNK-1] & b_chunk_s[CHUNK-1] & ~sum_ext_s[CHUNK-1]) |
                (~a_chunk_s[CHUNK-1] & ~b_chunk_s[CHUNK-1] & sum_ext_s[CHUNK-1]);
        slt_s = sum_ext_s[CHUNK-1] ^ ovf_s;

        valid_op_s = 1'b0;
        case (ctrl_r)
            4'b0000, 4'b0001, 4'b0010, 4'b0110,
            4'b0111, 4'b1100, 4'b1101: valid_op_s = 1'b1;
            default:                   valid_op_s = 1'b0;
        endcase
        arith_s = valid_op_s & ctrl_r[1];

        full_s = acc_r;
        full_s[(N-1)*CHUNK +: CHUNK] = chunk_res_s;

        if (!valid_op_s) begin
            final_s = '0;
        end else if (ctrl_r[1:0] == 2'b11) begin
            final_s = {{(WIDTH-1){1'b0}}, slt_s};
        end else begin
            final_s = full_s;
        end
    end

    // Control FSM with operand latches, chunk accumulator and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            a_r      <= '0;
            b_r      <= '0;
            acc_r    <= '0;
            ctrl_r   <= 4'b0000;
            idx_r    <= '0;
            carry_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= '0;
            zero_r   <= 1'b1;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (bus.start_i) begin
                        a_r     <= bus.src1_i;
                        b_r     <= bus.src2_i;
                        ctrl_r  <= bus.ctrl_i;
                        idx_r   <= '0;
                        carry_r <= bus.ctrl_i[2];
                        busy_r  <= 1'b1;
                        state_r <= ST_BUSY;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    acc_r[int'(idx_r)*CHUNK +: CHUNK] <= chunk_res_s;
                    carry_r <= sum_ext_s[CHUNK];
                    idx_r   <= idx_r + 1'b1;
                    if (idx_r == LAST_IDX) begin
                        state_r  <= ST_DONE;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        result_r <= final_s;
                        zero_r   <= (final_s == '0);
                        cout_r   <= arith_s & sum_ext_s[CHUNK];
                        ovf_r    <= arith_s & ovf_s;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o     = busy_r;
    assign bus.done_o     = done_r;
    assign bus.result_o   = result_r;
    assign bus.zero_o     = zero_r;
    assign bus.cout_o     = cout_r;
    assign bus.overflow_o = ovf_r;
endmodule
